spi_i2c_bridge_ctrl: RTL and testbench

- Framing and buffering controller between the SPI slave byte interface and the I2C master inside the protocol conversion unit.
- Collects an SPI frame (header plus payload, delimited by chip-select) into a write FIFO, then issues one I2C transaction with the decoded address, direction and length.
- Read data from I2C goes into a read FIFO, which the SPI slave drains on its next frame.
- Generalises the fixed single-byte bridge to variable-length, multi-byte, bidirectional transfers.

---
 rtl/bridge_pkg.sv | 27 ++
 rtl/bridge_fifo.sv | 61 ++++++
 rtl/spi_i2c_bridge_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_i2c_bridge_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared state encoding and status-byte layout for the SPI-to-I2C framing bridge.
// The status byte is only produced when BRIDGE_STATUS_EN is defined.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LEN,
        ST_COLLECT,
        ST_ISSUE,
        ST_XFER,
        ST_DONE,
        ST_ERR
    } bridge_state_t;

    localparam int unsigned STAT_OVF_BIT  = 0;
    localparam int unsigned STAT_NACK_BIT = 1;
    localparam logic [7:0]  IDLE_FILL     = 8'hFF;

    function automatic logic [7:0] status_byte(input logic nack, input logic ovf);
        logic [7:0] s;
        s                = '0;
        s[STAT_NACK_BIT] = nack;
        s[STAT_OVF_BIT]  = ovf;
        return s;
    endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Synchronous first-word-fall-through FIFO with flush, used for both bridge directions.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module bridge_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic                    pop_i,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_i2c_bridge_ctrl.sv
// Frames SPI bytes into variable-length I2C transactions and buffers read data for MISO.
// Define BRIDGE_STATUS_EN to append a {nack, overflow} status byte after each transaction.
module spi_i2c_bridge_ctrl
    import bridge_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_L,
    input  logic                         i_CS_n,
    input  logic                         i_RX_DV,
    input  logic [DATA_W-1:0]            i_RX_Byte,
    output logic                         o_TX_DV,
    output logic [DATA_W-1:0]            o_TX_Byte,
    input  logic                         i_TX_Req,
    output logic                         o_I2C_Start,
    output logic [ADDR_W-1:0]            o_I2C_Addr,
    output logic                         o_I2C_RW,
    output logic [$clog2(MAX_LEN+1)-1:0] o_I2C_Len,
    output logic                         o_I2C_WValid,
    output logic [DATA_W-1:0]            o_I2C_WData,
    input  logic                         i_I2C_WReady,
    input  logic                         i_I2C_RValid,
    input  logic [DATA_W-1:0]            i_I2C_RData,
    input  logic                         i_I2C_Done,
    input  logic                         i_I2C_Nack,
    output logic                         o_Busy,
    output logic                         o_Err
);

    localparam int unsigned     LEN_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned     CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] MAX_LEN_B = DATA_W'(MAX_LEN);

    bridge_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [LEN_W-1:0]  len_q;
    logic              hdr_done_q;
    logic              start_q;
    logic              busy_q;
    logic              err_q;
    logic              tx_dv_q;
    logic [DATA_W-1:0] tx_byte_q;
`ifdef BRIDGE_STATUS_EN
    logic              nack_q;
    logic              ovf_q;
`endif

    logic              rx_take;
    logic              rd_in;
    logic              wr_valid;
    logic [CNT_W-1:0]  len_cnt;

    logic              wf_push, wf_pop, wf_flush, wf_full, wf_empty;
    logic [DATA_W-1:0] wf_rdata;
    logic [CNT_W-1:0]  wf_count;
    logic              rf_push, rf_pop, rf_full, rf_empty;
    logic [DATA_W-1:0] rf_wdata, rf_rdata;
    logic [CNT_W-1:0]  rf_count;
    logic              unused_rf_count;

    assign unused_rf_count = ^rf_count;
    assign len_cnt         = CNT_W'(len_q);

    // The write FIFO doubles as the payload counter: it is always empty on entry to COLLECT.
    always_comb begin
        rx_take  = i_RX_DV && !i_CS_n;
        wf_push  = (state_q == ST_COLLECT) && rx_take && (wf_count != len_cnt) && !wf_full;
        wr_valid = (state_q == ST_XFER) && !rw_q && !wf_empty;
        wf_pop   = wr_valid && i_I2C_WReady;
        wf_flush = (state_q == ST_ERR) || (state_q == ST_DONE) ||
                   ((state_q == ST_XFER) && i_I2C_Done);
        rd_in    = (state_q == ST_XFER) && rw_q && i_I2C_RValid;
        rf_push  = rd_in && !rf_full;
        rf_wdata = i_I2C_RData;
`ifdef BRIDGE_STATUS_EN
        if (state_q == ST_DONE) begin
            rf_push  = !rf_full;
            rf_wdata = DATA_W'(status_byte(nack_q, ovf_q));
        end
`endif
        rf_pop   = i_TX_Req && !rf_empty;
    end

    bridge_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk_i   (i_Clk),
        .rst_ni  (i_Rst_L),
        .flush_i (wf_flush),
        .push_i  (wf_push),
        .wdata_i (i_RX_Byte),
        .pop_i   (wf_pop),
        .rdata_o (wf_rdata),
        .full_o  (wf_full),
        .empty_o (wf_empty),
        .count_o (wf_count)
    );

    bridge_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rfifo (
        .clk_i   (i_Clk),
        .rst_ni  (i_Rst_L),
        .flush_i (1'b0),
        .push_i  (rf_push),
        .wdata_i (rf_wdata),
        .pop_i   (rf_pop),
        .rdata_o (rf_rdata),
        .full_o  (rf_full),
        .empty_o (rf_empty),
        .count_o (rf_count)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            len_q      <= '0;
            hdr_done_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef BRIDGE_STATUS_EN
            nack_q     <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_take) begin
                        addr_q     <= i_RX_Byte[ADDR_W:1];
                        rw_q       <= i_RX_Byte[0];
                        hdr_done_q <= 1'b0;
                        state_q    <= ST_HDR_LEN;
                    end
                end
                ST_HDR_LEN: begin
                    if (hdr_done_q) begin
                        // Read header complete; wait for the host to close the frame.
                        if (i_CS_n) begin
                            state_q <= ST_ISSUE;
                            start_q <= 1'b1;
                        end
                    end else if (i_CS_n) begin
                        state_q <= ST_ERR;
                    end else if (i_RX_DV) begin
                        if ((i_RX_Byte == '0) || (i_RX_Byte > MAX_LEN_B)) begin
                            state_q <= ST_ERR;
                        end else begin
                            len_q  <= LEN_W'(i_RX_Byte);
                            err_q  <= 1'b0;
                            busy_q <= 1'b1;
                            if (rw_q) begin
                                hdr_done_q <= 1'b1;
                            end else begin
                                state_q <= ST_COLLECT;
                            end
                        end
                    end
                end
                ST_COLLECT: begin
                    if (i_CS_n) begin
                        if (wf_count == len_cnt) begin
                            state_q <= ST_ISSUE;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end else if (i_RX_DV && (wf_count == len_cnt)) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_XFER;
`ifdef BRIDGE_STATUS_EN
                    nack_q  <= 1'b0;
                    ovf_q   <= 1'b0;
`endif
                end
                ST_XFER: begin
                    if (rd_in && rf_full) begin
                        err_q <= 1'b1;
`ifdef BRIDGE_STATUS_EN
                        ovf_q <= 1'b1;
`endif
                    end
                    if (i_I2C_Done) begin
                        state_q <= ST_DONE;
                        if (i_I2C_Nack) begin
                            err_q <= 1'b1;
                        end
`ifdef BRIDGE_STATUS_EN
                        nack_q  <= i_I2C_Nack;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_ERR: begin
                    err_q <= 1'b1;
                    if (i_CS_n) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            tx_dv_q <= i_TX_Req;
            if (i_TX_Req) begin
                tx_byte_q <= rf_empty ? DATA_W'(IDLE_FILL) : rf_rdata;
            end
        end
    end

    assign o_TX_DV      = tx_dv_q;
    assign o_TX_Byte    = tx_byte_q;
    assign o_I2C_Start  = start_q;
    assign o_I2C_Addr   = addr_q;
    assign o_I2C_RW     = rw_q;
    assign o_I2C_Len    = len_q;
    assign o_I2C_WValid = wr_valid;
    assign o_I2C_WData  = wr_valid ? wf_rdata : '0;
    assign o_Busy       = busy_q;
    assign o_Err        = err_q;

endmodule

// File: tb/tb_spi_i2c_bridge_ctrl.sv
// Self-checking bench for spi_i2c_bridge_ctrl: directed cases plus randomized transactions
// against a queue-based model of the read path; honours BRIDGE_STATUS_EN.
`timescale 1ns/1ps
module tb_spi_i2c_bridge_ctrl;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int MAX_LEN    = 16;
    localparam int ADDR_W     = 7;
    localparam int LEN_W      = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_l  = 1'b0;
    logic              cs_n   = 1'b1;
    logic              rx_dv  = 1'b0;
    logic [7:0]        rx_byte = '0;
    logic              tx_req = 1'b0;
    logic              wready = 1'b0;
    logic              rvalid = 1'b0;
    logic [7:0]        rdata  = '0;
    logic              done   = 1'b0;
    logic              nack   = 1'b0;

    logic              o_TX_DV, o_I2C_Start, o_I2C_RW, o_I2C_WValid, o_Busy, o_Err;
    logic [7:0]        o_TX_Byte, o_I2C_WData;
    logic [ADDR_W-1:0] o_I2C_Addr;
    logic [LEN_W-1:0]  o_I2C_Len;

    spi_i2c_bridge_ctrl #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_CS_n(cs_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .i_TX_Req(tx_req),
        .o_I2C_Start(o_I2C_Start), .o_I2C_Addr(o_I2C_Addr), .o_I2C_RW(o_I2C_RW),
        .o_I2C_Len(o_I2C_Len), .o_I2C_WValid(o_I2C_WValid), .o_I2C_WData(o_I2C_WData),
        .i_I2C_WReady(wready), .i_I2C_RValid(rvalid), .i_I2C_RData(rdata),
        .i_I2C_Done(done), .i_I2C_Nack(nack), .o_Busy(o_Busy), .o_Err(o_Err)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Start-pulse monitor: counts every cycle Start is seen and captures the request fields.
    int                start_cnt = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              last_rw   = 1'b0;
    logic [LEN_W-1:0]  last_len  = '0;
    always @(negedge clk) begin
        if (o_I2C_Start) begin
            start_cnt++;
            last_addr = o_I2C_Addr;
            last_rw   = o_I2C_RW;
            last_len  = o_I2C_Len;
        end
    end

    // Reference model: bytes the SPI host should read back, and the expected error flag.
    logic [7:0] mq[$];
    bit         m_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b[$]);
        cs_n = 1'b0;
        tick(1);
        foreach (b[i]) begin
            rx_dv   = 1'b1;
            rx_byte = b[i];
            tick(1);
            rx_dv   = 1'b0;
            tick($urandom_range(0, 2));
        end
        cs_n = 1'b1;
        tick(1);
    endtask

    task automatic i2c_serve(input bit is_rd, input logic [7:0] rd_data[$], input int n_bytes,
                             input bit do_nack, output logic [7:0] wr_got[$], output bit timed_out);
        int budget;
        wr_got    = {};
        timed_out = 1'b0;
        budget    = 0;
        while (!o_I2C_Start && budget < 100) begin
            tick(1);
            budget++;
        end
        if (!o_I2C_Start) begin
            timed_out = 1'b1;
            return;
        end
        tick(1);
        check_eq("busy_in_xfer", 32'(o_Busy), 32'd1);
        if (is_rd) begin
            for (int i = 0; i < n_bytes; i++) begin
                tick($urandom_range(0, 2));
                rvalid = 1'b1;
                rdata  = rd_data[i];
                tick(1);
                rvalid = 1'b0;
            end
        end else begin
            budget = 0;
            while (wr_got.size() < n_bytes && budget < 400) begin
                wready = ($urandom_range(0, 3) != 0);
                if (o_I2C_WValid && wready) wr_got.push_back(o_I2C_WData);
                tick(1);
                budget++;
            end
            wready = 1'b0;
            if (wr_got.size() < n_bytes) timed_out = 1'b1;
        end
        done = 1'b1;
        nack = do_nack;
        tick(1);
        done = 1'b0;
        nack = 1'b0;
        tick(2);
    endtask

    task automatic drain_check(input logic [7:0] exp[$]);
        for (int i = 0; i <= exp.size(); i++) begin
            tx_req = 1'b1;
            tick(1);
            tx_req = 1'b0;
            check_eq("tx_dv", 32'(o_TX_DV), 32'd1);
            check_eq("tx_byte", 32'(o_TX_Byte), 32'((i < exp.size()) ? exp[i] : 8'hFF));
            tick(1);
        end
    endtask

    task automatic run_txn(input logic [ADDR_W-1:0] addr, input bit rw, input int len,
                           input logic [7:0] data[$], input bit do_nack, input int keep);
        logic [7:0] frame[$];
        logic [7:0] got[$];
        bit         to;
        int         s0;
        int         n_exp;
        frame = {};
        frame.push_back({addr, rw});
        frame.push_back(8'(len));
        if (!rw) foreach (data[i]) frame.push_back(data[i]);
        s0 = start_cnt;
        send_frame(frame);
        if (len < 1 || len > MAX_LEN) begin
            tick(5);
            check_eq("badlen_no_start", 32'(start_cnt - s0), 32'd0);
            check_eq("badlen_err", 32'(o_Err), 32'd1);
            m_err = 1'b1;
            return;
        end
        n_exp = do_nack ? keep : len;
        i2c_serve(rw, data, n_exp, do_nack, got, to);
        check_eq("xfer_timeout", 32'(to), 32'd0);
        check_eq("start_count", 32'(start_cnt - s0), 32'd1);
        check_eq("i2c_addr", 32'(last_addr), 32'(addr));
        check_eq("i2c_rw", 32'(last_rw), 32'(rw));
        check_eq("i2c_len", 32'(last_len), 32'(len));
        if (!rw) begin
            check_eq("wdata_count", 32'(got.size()), 32'(n_exp));
            foreach (got[i]) check_eq("wdata", 32'(got[i]), 32'(data[i]));
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(data[i]);
                else m_err = 1'b1;
            end
        end
        m_err = do_nack;
`ifdef BRIDGE_STATUS_EN
        if (mq.size() < FIFO_DEPTH) mq.push_back({6'b0, do_nack, 1'b0});
`endif
        check_eq("err_after_txn", 32'(o_Err), 32'(m_err));
        check_eq("busy_after_txn", 32'(o_Busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] frame[$];
        int         s0;
        int         budget;
        bit         seen;

        // Reset state
        rst_l = 1'b0;
        tick(3);
        check_eq("rst_start",  32'(o_I2C_Start), 32'd0);
        check_eq("rst_wvalid", 32'(o_I2C_WValid), 32'd0);
        check_eq("rst_txdv",   32'(o_TX_DV), 32'd0);
        check_eq("rst_busy",   32'(o_Busy), 32'd0);
        check_eq("rst_err",    32'(o_Err), 32'd0);
        check_eq("rst_fields", 32'({o_I2C_Addr, o_I2C_RW, o_I2C_Len, o_TX_Byte}), 32'd0);
        rst_l = 1'b1;
        tick(2);

        // Write 3 bytes to 0x50
        d = {8'hA1, 8'hB2, 8'hC3};
        run_txn(7'h50, 1'b0, 3, d, 1'b0, 0);
        drain_check(mq);
        mq = {};

        // Read 2 bytes from 0x50, then an empty-FIFO request yields the fill byte
        d = {8'h5A, 8'h2A};
        run_txn(7'h50, 1'b1, 2, d, 1'b0, 0);
        drain_check(mq);
        mq = {};

        // Bad lengths, then a valid header clears the error
        d = {};
        run_txn(7'h21, 1'b0, 0, d, 1'b0, 0);
        run_txn(7'h21, 1'b1, 17, d, 1'b0, 0);
        d = {8'h3C};
        run_txn(7'h22, 1'b0, 1, d, 1'b0, 0);
        drain_check(mq);
        mq = {};

        // Short frame: header promises 4 bytes, CS rises after 2
        s0    = start_cnt;
        frame = {8'hA0, 8'h04, 8'h11, 8'h22};
        send_frame(frame);
        tick(5);
        check_eq("short_no_start", 32'(start_cnt - s0), 32'd0);
        check_eq("short_err", 32'(o_Err), 32'd1);
        check_eq("short_busy", 32'(o_Busy), 32'd0);
        d = {8'h77};
        run_txn(7'h50, 1'b0, 1, d, 1'b0, 0);
        drain_check(mq);
        mq = {};

        // NACK after the first write byte
        d = {8'hA1, 8'hB2, 8'hC3};
        run_txn(7'h50, 1'b0, 3, d, 1'b1, 1);
        drain_check(mq);
        mq = {};

        // Reset in the middle of a write transfer
        frame = {8'hA0, 8'h03, 8'h11, 8'h22, 8'h33};
        send_frame(frame);
        budget = 0;
        while (!o_I2C_Start && budget < 100) begin tick(1); budget++; end
        check_eq("rstx_start_seen", 32'(o_I2C_Start), 32'd1);
        tick(1);
        seen   = 1'b0;
        budget = 0;
        while (!seen && budget < 50) begin
            wready = 1'b1;
            if (o_I2C_WValid) seen = 1'b1;
            tick(1);
            budget++;
        end
        check_eq("rstx_one_byte", 32'(seen), 32'd1);
        wready = 1'b0;
        rst_l  = 1'b0;
        tick(1);
        check_eq("rstx_start",  32'(o_I2C_Start), 32'd0);
        check_eq("rstx_wvalid", 32'(o_I2C_WValid), 32'd0);
        check_eq("rstx_busy",   32'(o_Busy), 32'd0);
        check_eq("rstx_err",    32'(o_Err), 32'd0);
        check_eq("rstx_fields", 32'({o_I2C_Addr, o_I2C_RW, o_I2C_Len, o_I2C_WData, o_TX_DV}), 32'd0);
        rst_l  = 1'b1;
        s0     = start_cnt;
        seen   = 1'b0;
        wready = 1'b1;
        repeat (30) begin
            if (o_I2C_WValid || o_I2C_Start) seen = 1'b1;
            tick(1);
        end
        wready = 1'b0;
        check_eq("rstx_quiet", 32'(seen), 32'd0);
        check_eq("rstx_no_start", 32'(start_cnt - s0), 32'd0);
        m_err = 1'b0;
        mq    = {};
        drain_check(mq);
        d = {8'h99, 8'h66};
        run_txn(7'h0F, 1'b0, 2, d, 1'b0, 0);
        drain_check(mq);
        mq = {};

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            logic [ADDR_W-1:0] a;
            bit                rw, nk;
            int                len, keep;
            a  = ADDR_W'($urandom);
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
                nk  = 1'b0;
            end else begin
                len = $urandom_range(1, MAX_LEN);
                nk  = ($urandom_range(0, 3) == 0);
            end
            keep = (nk && len > 0) ? int'($urandom_range(0, len - 1)) : 0;
            d = {};
            if (len >= 1 && len <= MAX_LEN) begin
                for (int i = 0; i < len; i++) d.push_back(8'($urandom));
            end
            run_txn(a, rw, len, d, nk, keep);
            drain_check(mq);
            mq = {};
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
